control_multiciclo: RTL and testbench

- Multi-cycle main control FSM for the multi-cycle RISC-V datapath; successor to the single-cycle main decoder.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB with ready handshakes to instruction and data memory.
- Enforces a parametrised memory timeout and raises exceptions with a cause code.
- Decoded datapath selects are held stable from DECODE until the instruction retires.

---
 rtl/control_multiciclo_if.sv | 36 +++
 rtl/control_multiciclo.sv | 256 +++++++++++++++++++++++++
 tb/tb_control_multiciclo.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_multiciclo_if.sv
// Control bundle between the multi-cycle main control FSM and the datapath / memories.
// The master side is the controller: it samples the opcode and memory readies and
// drives strobes, decoded selects and status. The slave side is the datapath/memory view.
interface control_multiciclo_if;
  logic [6:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       if_req;
  logic       ir_we;
  logic       pc_we;
  logic [2:0] RI;
  logic [1:0] LS;
  logic [2:0] BJ;
  logic [1:0] Data_S;
  logic       ALU_S;
  logic       Reg_W;
  logic       Mem_R;
  logic       Mem_W;
  logic       EXC;
  logic [1:0] exc_cause;
  logic       halted;
  logic       instr_done;
  logic [2:0] state;

  modport master (
    input  opcode, imem_ready, dmem_ready,
    output if_req, ir_we, pc_we, RI, LS, BJ, Data_S, ALU_S,
           Reg_W, Mem_R, Mem_W, EXC, exc_cause, halted, instr_done, state
  );

  modport slave (
    output opcode, imem_ready, dmem_ready,
    input  if_req, ir_we, pc_we, RI, LS, BJ, Data_S, ALU_S,
           Reg_W, Mem_R, Mem_W, EXC, exc_cause, halted, instr_done, state
  );
endinterface

// File: rtl/control_multiciclo.sv
// Multi-cycle main control FSM for the RISC-V datapath.
// Walks FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB), waits on memory readies with a
// bounded counter, and traps with a cause code on illegal opcodes or memory timeouts.
// Decoded selects are captured at the end of DECODE and held until the next DECODE,
// so the datapath sees stable selects for the whole life of the instruction.
// MEM_TIMEOUT must be at least 1 and must fit in CNT_W bits (2**CNT_W > MEM_TIMEOUT).
module control_multiciclo #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter int HALT_ON_EXC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  control_multiciclo_if.master io_ctrl
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_FETCH   = 2'b10;
  localparam logic [1:0] CAUSE_DATA    = 2'b11;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic             HALT_EN     = (HALT_ON_EXC != 0);

  // Registered state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cause;
  logic             r_trapExit;
  logic [2:0]       r_riSel;
  logic [1:0]       r_lsSel;
  logic [2:0]       r_bjSel;
  logic [1:0]       r_dataSel;
  logic             r_aluSel;

  // Combinational decode of the current opcode
  logic [2:0]       w_decRi;
  logic [1:0]       w_decLs;
  logic [2:0]       w_decBj;
  logic [1:0]       w_decData;
  logic             w_decAlu;
  logic             w_illegal;

  // Next-state values
  state_t           w_nextState;
  logic [CNT_W-1:0] w_nextCnt;
  logic [1:0]       w_nextCause;
  logic             w_nextTrapExit;
  logic             w_loadFields;

  // Instruction class, derived from the held selects so it stays valid after DECODE
  logic             w_isLoad;
  logic             w_isStore;
  logic             w_isBranch;
  logic             w_cntExpired;

  assign w_isLoad     = (r_lsSel == 2'b10);
  assign w_isStore    = (r_lsSel == 2'b01);
  assign w_isBranch   = (r_bjSel == 3'b001);
  assign w_cntExpired = (r_cnt == TIMEOUT_CNT);

  // Main opcode decoder; anything outside the table decodes to all-zero selects and flags illegal
  always_comb begin
    w_decRi   = 3'b000;
    w_decLs   = 2'b00;
    w_decBj   = 3'b000;
    w_decData = 2'b00;
    w_decAlu  = 1'b0;
    w_illegal = 1'b0;
    case (io_ctrl.opcode)
      OP_R: begin
        w_decRi = 3'b001;
      end
      OP_I: begin
        w_decRi  = 3'b010;
        w_decAlu = 1'b1;
      end
      OP_LOAD: begin
        w_decRi   = 3'b110;
        w_decLs   = 2'b10;
        w_decData = 2'b01;
        w_decAlu  = 1'b1;
      end
      OP_STORE: begin
        w_decRi   = 3'b110;
        w_decLs   = 2'b01;
        w_decData = 2'b01;
        w_decAlu  = 1'b1;
      end
      OP_BRANCH: begin
        w_decRi = 3'b101;
        w_decBj = 3'b001;
      end
      OP_JALR: begin
        w_decBj   = 3'b101;
        w_decData = 2'b11;
      end
      OP_JAL: begin
        w_decBj   = 3'b100;
        w_decData = 2'b11;
      end
      OP_AUIPC: begin
        w_decBj = 3'b010;
      end
      OP_LUI: begin
        w_decData = 2'b10;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Next-state and strobe logic; readies are only looked at in FETCH and MEM
  always_comb begin
    w_nextState        = r_state;
    w_nextCnt          = '0;
    w_nextCause        = r_cause;
    w_nextTrapExit     = 1'b0;
    w_loadFields       = 1'b0;
    io_ctrl.if_req     = 1'b0;
    io_ctrl.ir_we      = 1'b0;
    io_ctrl.pc_we      = 1'b0;
    io_ctrl.Reg_W      = 1'b0;
    io_ctrl.Mem_R      = 1'b0;
    io_ctrl.Mem_W      = 1'b0;
    io_ctrl.instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        io_ctrl.if_req = 1'b1;
        io_ctrl.pc_we  = r_trapExit;
        if (io_ctrl.imem_ready) begin
          io_ctrl.ir_we = 1'b1;
          w_nextState   = S_DECODE;
        end else if (w_cntExpired) begin
          w_nextState = S_TRAP;
          w_nextCause = CAUSE_FETCH;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
      S_DECODE: begin
        w_loadFields = 1'b1;
        if (w_illegal) begin
          w_nextState = S_TRAP;
          w_nextCause = CAUSE_ILLEGAL;
        end else begin
          w_nextState = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (w_isLoad || w_isStore) begin
          w_nextState = S_MEM;
        end else if (w_isBranch) begin
          io_ctrl.pc_we      = 1'b1;
          io_ctrl.instr_done = 1'b1;
          w_nextState        = S_FETCH;
        end else begin
          w_nextState = S_WB;
        end
      end
      S_MEM: begin
        io_ctrl.Mem_R = w_isLoad;
        io_ctrl.Mem_W = w_isStore;
        if (io_ctrl.dmem_ready) begin
          if (w_isLoad) begin
            w_nextState = S_WB;
          end else begin
            io_ctrl.pc_we      = 1'b1;
            io_ctrl.instr_done = 1'b1;
            w_nextState        = S_FETCH;
          end
        end else if (w_cntExpired) begin
          w_nextState = S_TRAP;
          w_nextCause = CAUSE_DATA;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
      S_WB: begin
        io_ctrl.Reg_W      = 1'b1;
        io_ctrl.pc_we      = 1'b1;
        io_ctrl.instr_done = 1'b1;
        w_nextState        = S_FETCH;
      end
      S_TRAP: begin
        if (!HALT_EN) begin
          w_nextState    = S_FETCH;
          w_nextCause    = CAUSE_NONE;
          w_nextTrapExit = 1'b1;
        end
      end
      default: begin
        w_nextState = S_FETCH;
        w_nextCause = CAUSE_NONE;
      end
    endcase
  end

  // State, wait counter, cause and held selects; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_cnt      <= '0;
      r_cause    <= CAUSE_NONE;
      r_trapExit <= 1'b0;
      r_riSel    <= 3'b000;
      r_lsSel    <= 2'b00;
      r_bjSel    <= 3'b000;
      r_dataSel  <= 2'b00;
      r_aluSel   <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      r_cause    <= w_nextCause;
      r_trapExit <= w_nextTrapExit;
      if (w_loadFields) begin
        r_riSel   <= w_decRi;
        r_lsSel   <= w_decLs;
        r_bjSel   <= w_decBj;
        r_dataSel <= w_decData;
        r_aluSel  <= w_decAlu;
      end
    end
  end

  assign io_ctrl.RI        = r_riSel;
  assign io_ctrl.LS        = r_lsSel;
  assign io_ctrl.BJ        = r_bjSel;
  assign io_ctrl.Data_S    = r_dataSel;
  assign io_ctrl.ALU_S     = r_aluSel;
  assign io_ctrl.EXC       = (r_state == S_TRAP);
  assign io_ctrl.halted    = (r_state == S_TRAP) && HALT_EN;
  assign io_ctrl.exc_cause = r_cause;
  assign io_ctrl.state     = r_state;

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: two instances (halting and recovering trap behaviour).
// Each driven cycle pushes its hand-derived expected output vector onto a per-instance
// queue; a monitor pops and compares one vector per cycle on the falling edge.
module tb_control_multiciclo;

  localparam int TIMEOUT = 15;

  localparam int K_WB     = 0;
  localparam int K_LOAD   = 1;
  localparam int K_STORE  = 2;
  localparam int K_BRANCH = 3;

  // Selects packed as {RI,LS,BJ,Data_S,ALU_S}
  localparam logic [10:0] F_ZERO   = 11'b000_00_000_00_0;
  localparam logic [10:0] F_R      = 11'b001_00_000_00_0;
  localparam logic [10:0] F_I      = 11'b010_00_000_00_1;
  localparam logic [10:0] F_LOAD   = 11'b110_10_000_01_1;
  localparam logic [10:0] F_STORE  = 11'b110_01_000_01_1;
  localparam logic [10:0] F_BRANCH = 11'b101_00_001_00_0;
  localparam logic [10:0] F_JALR   = 11'b000_00_101_11_0;
  localparam logic [10:0] F_JAL    = 11'b000_00_100_11_0;
  localparam logic [10:0] F_AUIPC  = 11'b000_00_010_00_0;
  localparam logic [10:0] F_LUI    = 11'b000_00_000_10_0;

  typedef struct packed {
    logic [2:0]  st;
    logic        ifReq;
    logic        irWe;
    logic        pcWe;
    logic [10:0] fields;
    logic        regW;
    logic        memR;
    logic        memW;
    logic        exc;
    logic [1:0]  cause;
    logic        halted;
    logic        done;
  } outVec_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  control_multiciclo_if bus0 ();
  control_multiciclo_if bus1 ();

  control_multiciclo #(.MEM_TIMEOUT(15), .CNT_W(4), .HALT_ON_EXC(1)) dut0 (
    .clk     (clk),
    .rst     (rst0),
    .io_ctrl (bus0)
  );

  control_multiciclo #(.MEM_TIMEOUT(15), .CNT_W(4), .HALT_ON_EXC(0)) dut1 (
    .clk     (clk),
    .rst     (rst1),
    .io_ctrl (bus1)
  );

  outVec_t     q0[$];
  outVec_t     q1[$];
  string       l0[$];
  string       l1[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [10:0] held[2];
  outVec_t     exp0;
  outVec_t     exp1;
  string       name0;
  string       name1;

  function automatic outVec_t mk(input logic [2:0] st, input logic ifReq, input logic irWe,
                                 input logic pcWe, input logic [10:0] f, input logic regW,
                                 input logic memR, input logic memW, input logic exc,
                                 input logic [1:0] cause, input logic hlt, input logic done);
    outVec_t v;
    v.st     = st;
    v.ifReq  = ifReq;
    v.irWe   = irWe;
    v.pcWe   = pcWe;
    v.fields = f;
    v.regW   = regW;
    v.memR   = memR;
    v.memW   = memW;
    v.exc    = exc;
    v.cause  = cause;
    v.halted = hlt;
    v.done   = done;
    return v;
  endfunction

  function automatic outVec_t sample(input int d);
    outVec_t v;
    if (d == 0) begin
      v.st     = bus0.state;
      v.ifReq  = bus0.if_req;
      v.irWe   = bus0.ir_we;
      v.pcWe   = bus0.pc_we;
      v.fields = {bus0.RI, bus0.LS, bus0.BJ, bus0.Data_S, bus0.ALU_S};
      v.regW   = bus0.Reg_W;
      v.memR   = bus0.Mem_R;
      v.memW   = bus0.Mem_W;
      v.exc    = bus0.EXC;
      v.cause  = bus0.exc_cause;
      v.halted = bus0.halted;
      v.done   = bus0.instr_done;
    end else begin
      v.st     = bus1.state;
      v.ifReq  = bus1.if_req;
      v.irWe   = bus1.ir_we;
      v.pcWe   = bus1.pc_we;
      v.fields = {bus1.RI, bus1.LS, bus1.BJ, bus1.Data_S, bus1.ALU_S};
      v.regW   = bus1.Reg_W;
      v.memR   = bus1.Mem_R;
      v.memW   = bus1.Mem_W;
      v.exc    = bus1.EXC;
      v.cause  = bus1.exc_cause;
      v.halted = bus1.halted;
      v.done   = bus1.instr_done;
    end
    return v;
  endfunction

  // Compare one presented output vector against the queued expectation
  task automatic checkOutput(input string name, input outVec_t act, input outVec_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual state=%0d vec=%h, required state=%0d vec=%h",
               name, act.st, act, exp.st, exp);
    end
  endtask

  // Monitor: one vector per cycle per instance, sampled on the falling edge
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      exp0  = q0.pop_front();
      name0 = l0.pop_front();
      checkOutput({"dut0/", name0}, sample(0), exp0);
    end
    if (q1.size() > 0) begin
      exp1  = q1.pop_front();
      name1 = l1.pop_front();
      checkOutput({"dut1/", name1}, sample(1), exp1);
    end
  end

  // Drive one cycle of inputs on an instance, queue its expectation, advance to just after the edge
  task automatic applyStimulus(input int d, input logic [6:0] op, input logic ir, input logic dr,
                               input outVec_t e, input string name);
    if (d == 0) begin
      bus0.opcode     = op;
      bus0.imem_ready = ir;
      bus0.dmem_ready = dr;
      q0.push_back(e);
      l0.push_back(name);
    end else begin
      bus1.opcode     = op;
      bus1.imem_ready = ir;
      bus1.dmem_ready = dr;
      q1.push_back(e);
      l1.push_back(name);
    end
    @(posedge clk);
    #1;
  endtask

  // First FETCH cycle after a non-halting trap: PC redirect, cause already cleared
  task automatic trapExit(input int d, input logic [10:0] f, input string name);
    applyStimulus(d, 7'b0, 1'b0, 1'b0, mk(3'd0, 1, 0, 1, f, 0, 0, 0, 0, 2'b00, 0, 0),
                  {name, "/exit"});
  endtask

  // One legal instruction; memWait > TIMEOUT runs the data timeout path instead
  task automatic runInstr(input int d, input logic [6:0] op, input logic [10:0] f, input int kind,
                          input int fetchWait, input int memWait, input logic noise,
                          input string name);
    logic [10:0] p;
    logic        isLd;
    logic        isSt;
    p    = held[d];
    isLd = (kind == K_LOAD);
    isSt = (kind == K_STORE);
    for (int i = 0; i < fetchWait; i++)
      applyStimulus(d, op, 1'b0, 1'b0, mk(3'd0, 1, 0, 0, p, 0, 0, 0, 0, 2'b00, 0, 0),
                    {name, "/fetchwait"});
    applyStimulus(d, op, 1'b1, 1'b0, mk(3'd0, 1, 1, 0, p, 0, 0, 0, 0, 2'b00, 0, 0),
                  {name, "/fetch"});
    applyStimulus(d, op, noise, noise, mk(3'd1, 0, 0, 0, p, 0, 0, 0, 0, 2'b00, 0, 0),
                  {name, "/decode"});
    held[d] = f;
    if (kind == K_BRANCH) begin
      applyStimulus(d, op, noise, noise, mk(3'd2, 0, 0, 1, f, 0, 0, 0, 0, 2'b00, 0, 1),
                    {name, "/execute"});
    end else begin
      applyStimulus(d, op, noise, noise, mk(3'd2, 0, 0, 0, f, 0, 0, 0, 0, 2'b00, 0, 0),
                    {name, "/execute"});
    end
    if (isLd || isSt) begin
      if (memWait > TIMEOUT) begin
        for (int i = 0; i <= TIMEOUT; i++)
          applyStimulus(d, op, 1'b0, 1'b0, mk(3'd3, 0, 0, 0, f, 0, isLd, isSt, 0, 2'b00, 0, 0),
                        {name, "/memwait"});
        applyStimulus(d, op, 1'b0, 1'b0, mk(3'd5, 0, 0, 0, f, 0, 0, 0, 1, 2'b11, d == 0, 0),
                      {name, "/dtimeout-trap"});
        if (d == 1) trapExit(d, f, name);
        return;
      end
      for (int i = 0; i < memWait; i++)
        applyStimulus(d, op, 1'b0, 1'b0, mk(3'd3, 0, 0, 0, f, 0, isLd, isSt, 0, 2'b00, 0, 0),
                      {name, "/memwait"});
      applyStimulus(d, op, 1'b0, 1'b1, mk(3'd3, 0, 0, isSt, f, 0, isLd, isSt, 0, 2'b00, 0, isSt),
                    {name, "/mem"});
    end
    if (kind == K_WB || isLd)
      applyStimulus(d, op, noise, noise, mk(3'd4, 0, 0, 1, f, 1, 0, 0, 0, 2'b00, 0, 1),
                    {name, "/wb"});
  endtask

  // Illegal opcode: FETCH, DECODE, then nTrap TRAP cycles with all selects cleared
  task automatic runIllegal(input int d, input logic [6:0] op, input logic hlt, input int nTrap,
                            input string name);
    logic [10:0] p;
    p = held[d];
    applyStimulus(d, op, 1'b1, 1'b0, mk(3'd0, 1, 1, 0, p, 0, 0, 0, 0, 2'b00, 0, 0),
                  {name, "/fetch"});
    applyStimulus(d, op, 1'b0, 1'b0, mk(3'd1, 0, 0, 0, p, 0, 0, 0, 0, 2'b00, 0, 0),
                  {name, "/decode"});
    held[d] = F_ZERO;
    for (int i = 0; i < nTrap; i++)
      applyStimulus(d, op, 1'b1, 1'b1, mk(3'd5, 0, 0, 0, F_ZERO, 0, 0, 0, 1, 2'b01, hlt, 0),
                    {name, "/trap"});
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    held[0] = F_ZERO;
    held[1] = F_ZERO;
    bus0.opcode = 7'b0; bus0.imem_ready = 1'b0; bus0.dmem_ready = 1'b0;
    bus1.opcode = 7'b0; bus1.imem_ready = 1'b0; bus1.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;

    // Halting instance: every opcode class, readies early/late, stray readies ignored
    runInstr(0, 7'b0110011, F_R,      K_WB,     0,  0, 1'b0, "R");
    runInstr(0, 7'b0010011, F_I,      K_WB,     2,  0, 1'b1, "I");
    runInstr(0, 7'b0000011, F_LOAD,   K_LOAD,   0,  3, 1'b0, "LOAD");
    runInstr(0, 7'b0100011, F_STORE,  K_STORE,  0,  0, 1'b0, "STORE");
    runInstr(0, 7'b1100011, F_BRANCH, K_BRANCH, 0,  0, 1'b0, "BRANCH");
    runInstr(0, 7'b1100111, F_JALR,   K_WB,     0,  0, 1'b1, "JALR");
    runInstr(0, 7'b1101111, F_JAL,    K_WB,     1,  0, 1'b0, "JAL");
    runInstr(0, 7'b0010111, F_AUIPC,  K_WB,     0,  0, 1'b0, "AUIPC");
    runInstr(0, 7'b0110111, F_LUI,    K_WB,     15, 0, 1'b0, "LUI-lastfetch");
    runInstr(0, 7'b0100011, F_STORE,  K_STORE,  0,  15, 1'b0, "STORE-lastmem");

    // Reset in the middle of a load's memory wait
    applyStimulus(0, 7'b0000011, 1'b1, 1'b0, mk(3'd0, 1, 1, 0, F_STORE, 0, 0, 0, 0, 2'b00, 0, 0), "rstmem/fetch");
    applyStimulus(0, 7'b0000011, 1'b0, 1'b0, mk(3'd1, 0, 0, 0, F_STORE, 0, 0, 0, 0, 2'b00, 0, 0), "rstmem/decode");
    applyStimulus(0, 7'b0000011, 1'b0, 1'b0, mk(3'd2, 0, 0, 0, F_LOAD, 0, 0, 0, 0, 2'b00, 0, 0), "rstmem/execute");
    applyStimulus(0, 7'b0000011, 1'b0, 1'b0, mk(3'd3, 0, 0, 0, F_LOAD, 0, 1, 0, 0, 2'b00, 0, 0), "rstmem/memwait");
    applyStimulus(0, 7'b0000011, 1'b0, 1'b0, mk(3'd3, 0, 0, 0, F_LOAD, 0, 1, 0, 0, 2'b00, 0, 0), "rstmem/memwait");
    rst0 = 1'b1;
    applyStimulus(0, 7'b0000011, 1'b0, 1'b1, mk(3'd3, 0, 0, 0, F_LOAD, 0, 1, 0, 0, 2'b00, 0, 0), "rstmem/rstcycle");
    rst0 = 1'b0;
    held[0] = F_ZERO;
    applyStimulus(0, 7'b0000011, 1'b0, 1'b0, mk(3'd0, 1, 0, 0, F_ZERO, 0, 0, 0, 0, 2'b00, 0, 0), "rstmem/after");

    // Illegal opcode halts until reset
    runIllegal(0, 7'b1111111, 1'b1, 20, "ILLEGAL");
    rst0 = 1'b1;
    applyStimulus(0, 7'b1111111, 1'b0, 1'b0, mk(3'd5, 0, 0, 0, F_ZERO, 0, 0, 0, 1, 2'b01, 1, 0), "ILLEGAL/rstcycle");
    rst0 = 1'b0;
    applyStimulus(0, 7'b1111111, 1'b0, 1'b0, mk(3'd0, 1, 0, 0, F_ZERO, 0, 0, 0, 0, 2'b00, 0, 0), "ILLEGAL/after");
    rst0 = 1'b1;

    // Recovering instance: fetch timeout, data timeout, illegal opcode, each returns to FETCH
    rst1 = 1'b0;
    for (int i = 0; i <= TIMEOUT; i++)
      applyStimulus(1, 7'b0110011, 1'b0, 1'b0, mk(3'd0, 1, 0, 0, F_ZERO, 0, 0, 0, 0, 2'b00, 0, 0), "FTO/fetchwait");
    applyStimulus(1, 7'b0110011, 1'b0, 1'b0, mk(3'd5, 0, 0, 0, F_ZERO, 0, 0, 0, 1, 2'b10, 0, 0), "FTO/trap");
    trapExit(1, F_ZERO, "FTO");
    runInstr(1, 7'b0110011, F_R,    K_WB,   1, 0,  1'b0, "R");
    runInstr(1, 7'b0000011, F_LOAD, K_LOAD, 0, 99, 1'b0, "LOAD-DTO");
    runIllegal(1, 7'b0000000, 1'b0, 1, "ILLEGAL");
    trapExit(1, F_ZERO, "ILLEGAL");
    runInstr(1, 7'b1100011, F_BRANCH, K_BRANCH, 0, 0, 1'b0, "BRANCH");
    rst1 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
